// File: rtl/bio_ram_arb_pkg.sv
// Shared types and helpers for the bio_ram_arb RAM arbiter.
package bio_ram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_NREQ = 4;
    localparam int DEF_AW   = 10;
    localparam int DEF_DW   = 32;
    localparam int DEF_MW   = 4;

    // Width of a requester index; never below 1 so a 2-requester build still has a bit.
    function automatic int idx_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/bio_rr_arb.sv
// Combinational round-robin picker: the valid request closest above i_ptr (with wrap) wins.
module bio_rr_arb
    import bio_ram_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = idx_w(DEF_NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    int w_best;
    int w_dist;

    // Distance from the pointer, modulo NREQ; smallest distance wins.
    always_comb begin
        w_best = NREQ;
        w_dist = 0;
        o_idx  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (j >= int'(i_ptr)) w_dist = j - int'(i_ptr);
            else                  w_dist = j + NREQ - int'(i_ptr);
            if (i_req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = IW'(j);
            end
        end
        o_any = (w_best < NREQ);
    end

    always_comb begin
        o_gnt = '0;
        for (int j = 0; j < NREQ; j++)
            o_gnt[j] = o_any && (o_idx == IW'(j));
    end

endmodule

// File: rtl/bio_ram_arb.sv
// Round-robin arbiter sharing one 1-cycle-latency single-port RAM between NREQ requesters.
// Optional BIO_RAM_ARB_ZEROIZE_EN: clears the whole RAM after reset before accepting requests.
module bio_ram_arb
    import bio_ram_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW,
    parameter int MW   = DEF_MW
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    input  logic [NREQ*MW-1:0]   req_wmask,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 ram_ce_n,
    output logic                 ram_wr_n,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_d,
    output logic [MW-1:0]        ram_wr_mask_n,
    input  logic [DW-1:0]        ram_q,
    output logic                 init_done
);

    localparam int IW = idx_w(NREQ);

    logic [IW-1:0]   r_rr_ptr;
    logic            r_rd_pend;
    logic [IW-1:0]   r_rd_id;
    logic [AW-1:0]   r_last_addr;
    logic [DW-1:0]   r_last_d;

    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic            w_run;
    logic            w_init;
    logic            w_fire;
    logic            w_we;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;
    logic [MW-1:0]   w_wmask;
    logic [IW-1:0]   w_ptr_nxt;

    bio_rr_arb #(.NREQ(NREQ), .IW(IW)) u_rr (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

`ifdef BIO_RAM_ARB_ZEROIZE_EN
    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_init_addr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_INIT;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_init_addr == '1) w_state_nxt = ST_RUN;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                 r_init_addr <= '0;
        else if (r_state == ST_INIT) r_init_addr <= r_init_addr + 1'b1;
    end

    assign w_run     = (r_state == ST_RUN);
    assign w_init    = (r_state == ST_INIT);
`else
    assign w_run     = 1'b1;
    assign w_init    = 1'b0;
`endif

    assign init_done = w_run;
    assign w_fire    = w_run && w_any;

    // Route the winner's request fields; the grant vector is one-hot so an OR-mux suffices.
    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_wmask = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_gnt[j]) begin
                w_we    = req_we[j];
                w_addr  = req_addr[j*AW +: AW];
                w_wdata = req_wdata[j*DW +: DW];
                w_wmask = req_wmask[j*MW +: MW];
            end
        end
    end

    // RAM pins are live from the grant; resetn gates them so nothing leaks out while in reset.
    always_comb begin
        req_ready     = '0;
        ram_ce_n      = 1'b1;
        ram_wr_n      = 1'b1;
        ram_wr_mask_n = '1;
        ram_addr      = r_last_addr;
        ram_d         = r_last_d;
`ifdef BIO_RAM_ARB_ZEROIZE_EN
        if (resetn && w_init) begin
            ram_ce_n      = 1'b0;
            ram_wr_n      = 1'b0;
            ram_wr_mask_n = '0;
            ram_addr      = r_init_addr;
            ram_d         = '0;
        end else
`endif
        if (resetn && w_fire) begin
            req_ready     = w_gnt;
            ram_ce_n      = 1'b0;
            ram_wr_n      = ~w_we;
            ram_wr_mask_n = w_we ? ~w_wmask : '1;
            ram_addr      = w_addr;
            ram_d         = w_wdata;
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int j = 0; j < NREQ; j++)
            rsp_valid[j] = r_rd_pend && (r_rd_id == IW'(j));
        rsp_rdata = r_rd_pend ? ram_q : '0;
    end

    assign w_ptr_nxt = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr    <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_id     <= '0;
            r_last_addr <= '0;
            r_last_d    <= '0;
        end else begin
            r_last_addr <= ram_addr;
            r_last_d    <= ram_d;
            r_rd_pend   <= w_fire && !w_we;
            if (w_fire) begin
                r_rr_ptr <= w_ptr_nxt;
                r_rd_id  <= w_idx;
            end
        end
    end

endmodule
